input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter STABLE_CYCLES, default 1_000_000, sets the consecutive synchronized-sample cycles needed to accept a level change (10 ms at 100 MHz).
REQ-002 Parameter SW_W, default 16, sets the switch bus width.
REQ-003 clk_i  input  1  single 100 MHz system clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 btnu_i, btnd_i, btnl_i, btnr_i, btnc_i  input  1 each  raw asynchronous push-button levels, 1 = pressed.
REQ-006 sw_i  input  SW_W  raw asynchronous slide-switch levels.
REQ-007 btnu_o, btnd_o, btnl_o, btnr_o, btnc_o  output  1 each  single-cycle press pulses.
REQ-008 sw_o  output  SW_W  debounced switch levels.

Function
REQ-009 Each of the 5 + SW_W inputs SHALL pass through its own 2-flop synchronizer before any other logic.
- Stable state: register `stable`, reset 0.
- Counter: `cnt`, width $clog2(STABLE_CYCLES+1).
REQ-010 Per bit, each cycle:
- synchronized sample == stable: cnt clears to 0.
- synchronized sample != stable and cnt == STABLE_CYCLES-1: stable takes the sample value and cnt clears to 0.
- otherwise cnt increments by 1.
- cnt never wraps.
REQ-011 Latency: a raw level held steady from rising edge N SHALL update stable on edge N+2+STABLE_CYCLES, exactly.
REQ-012 A raw disturbance shorter than STABLE_CYCLES synchronized cycles SHALL produce no change in stable and no pulse.
REQ-013 sw_o[i] SHALL equal the stable state of switch bit i and SHALL be registered.
REQ-014 Each btn*_o SHALL be 1 for exactly one cycle, the first cycle in which that button's stable state is 1 after being 0.
REQ-015 A stable 1->0 transition (release) SHALL produce no pulse.
REQ-016 A button held indefinitely SHALL produce exactly one pulse.
REQ-017 Bits are independent:
- Simultaneous presses on several buttons SHALL each pulse in their own qualifying cycle, possibly the same cycle.
- No cross-bit priority or masking.
REQ-018 STABLE_CYCLES = 1 is legal: a change is accepted after one mismatching synchronized sample.

Reset
REQ-019 With rst_i high at a rising edge, the following SHALL clear to 0 on that edge: synchronizer flops, stable, cnt, all btn*_o and sw_o.
REQ-020 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL emerge from a count started before reset.
REQ-021 A button held through reset deassertion SHALL be treated as a new press: one pulse after the full REQ-011 latency measured from the first non-reset edge.
REQ-022 Switches set to 1 during reset SHALL appear on sw_o after the same latency.

Structure
REQ-023 Package input_pkg SHALL hold:
- the default STABLE_CYCLES constant;
- the CLK_HZ = 100_000_000 constant;
- the button-index enum (U, D, L, R, C) used by the top level.
REQ-024 Sub-module debounce_cell (1-bit: synchronizer, counter, stable, rise pulse) SHALL be instantiated 5 + SW_W times via generate.
- The switch instances SHALL leave the pulse output unused.
REQ-025 No clock enables, derived clocks or asynchronous resets SHALL be used.

Verification (STABLE_CYCLES = 4)
REQ-026 btnc_i 0->1 at edge 10, held -> btnc_o = 1 only in the cycle after edge 16, with no further pulse over 100 cycles.
REQ-027 btnu_i high for 3 cycles, low for 2, repeated 10 times -> btnu_o never asserts.
REQ-028 sw_i = 16'hA5A5 at edge 5 -> sw_o = 16'h0000 through edge 10 and 16'hA5A5 from edge 11; then sw_i = 16'h0000 -> sw_o = 0 after 6 edges.
REQ-029 btnl_i and btnr_i rise on the same edge -> both pulses are asserted in the same single cycle.
REQ-030 btnd_i held; rst_i pulsed for 1 cycle at count 2 -> no pulse before reset release; exactly one pulse 6 edges after release; outputs = 0 during reset.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_pkg
// Purpose  : Shared constants and button indexing for the input conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package input_pkg;

  // System clock frequency the debounce window is derived from.
  localparam int CLK_HZ = 100_000_000;

  // Default debounce window: 10 ms worth of clock cycles.
  localparam int STABLE_CYCLES_DEFAULT = CLK_HZ / 100;

  // Number of push buttons on the board.
  localparam int NUM_BTN = 5;

  // Position of each button inside the internal button vectors.
  typedef enum logic [2:0] {
    BTN_U = 3'd0,
    BTN_D = 3'd1,
    BTN_L = 3'd2,
    BTN_R = 3'd3,
    BTN_C = 3'd4
  } btn_idx_e;

endpackage : input_pkg
`default_nettype wire

// File: rtl/input_conditioner_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module   : debounce_cell
// Purpose  : One-bit conditioner: 2-flop synchronizer, stability counter,
//            debounced level and registered rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_cell
  import input_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter bit RISE_EN       = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int                c_cnt_w = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  logic [1:0]         r_sync;
  logic               r_stable;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_rise;
  logic               w_sample;
  logic               w_accept;

  // The second synchronizer flop is the only view of the raw input.
  assign w_sample = r_sync[1];

  // A change is accepted on the last cycle of an unbroken mismatch run.
  // The counter clears on acceptance, so it never exceeds c_last.
  assign w_accept = (w_sample != r_stable) && (r_cnt == c_last);

  // Synchronize, count the mismatch run, update the level and flag rises.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync   <= 2'b00;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw_i};
      if (w_sample == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= w_sample;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + c_one;
      end
      // Pulse lands in the first cycle the new stable level is visible.
      r_rise <= w_accept & w_sample;
    end
  end

  assign level_o = r_stable;
  assign rise_o  = RISE_EN ? r_rise : 1'b0;

endmodule : debounce_cell
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Purpose  : Debounces five push buttons into single-cycle press pulses and
//            a slide-switch bus into registered stable levels.
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner
  import input_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int SW_W          = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            btnu_i,
  input  logic            btnd_i,
  input  logic            btnl_i,
  input  logic            btnr_i,
  input  logic            btnc_i,
  input  logic [SW_W-1:0] sw_i,
  output logic            btnu_o,
  output logic            btnd_o,
  output logic            btnl_o,
  output logic            btnr_o,
  output logic            btnc_o,
  output logic [SW_W-1:0] sw_o
);

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_btn_rise;
  logic [NUM_BTN-1:0] w_btn_level_unused;
  logic [SW_W-1:0]    w_sw_rise_unused;

  // Gather the buttons into one vector ordered by the package enum.
  assign w_btn_raw[BTN_U] = btnu_i;
  assign w_btn_raw[BTN_D] = btnd_i;
  assign w_btn_raw[BTN_L] = btnl_i;
  assign w_btn_raw[BTN_R] = btnr_i;
  assign w_btn_raw[BTN_C] = btnc_i;

  // Buttons only report presses; their debounced level is not exported.
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    debounce_cell #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RISE_EN       (1'b1)
    ) u_cell (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (w_btn_raw[b]),
      .level_o (w_btn_level_unused[b]),
      .rise_o  (w_btn_rise[b])
    );
  end

  // Switches only report their level; the pulse logic is disabled.
  for (genvar s = 0; s < SW_W; s++) begin : g_sw
    debounce_cell #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RISE_EN       (1'b0)
    ) u_cell (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (sw_i[s]),
      .level_o (sw_o[s]),
      .rise_o  (w_sw_rise_unused[s])
    );
  end

  assign btnu_o = w_btn_rise[BTN_U];
  assign btnd_o = w_btn_rise[BTN_D];
  assign btnl_o = w_btn_rise[BTN_L];
  assign btnr_o = w_btn_rise[BTN_R];
  assign btnc_o = w_btn_rise[BTN_C];

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_conditioner
// Purpose  : Directed self-checking bench for input_conditioner with a
//            4-cycle debounce window plus a 1-cycle window instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic        btnu, btnd, btnl, btnr, btnc;
  logic [15:0] sw;
  logic        btnu_o, btnd_o, btnl_o, btnr_o, btnc_o;
  logic [15:0] sw_o;
  logic        u1_btnu_o, u1_btnd_o, u1_btnl_o, u1_btnr_o, u1_btnc_o;
  logic [3:0]  u1_sw_o;

  int errors = 0;
  int checks = 0;
  int pulses;

  always #5 clk = ~clk;

  input_conditioner #(.STABLE_CYCLES(4), .SW_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .btnu_i(btnu), .btnd_i(btnd), .btnl_i(btnl), .btnr_i(btnr), .btnc_i(btnc),
    .sw_i(sw),
    .btnu_o(btnu_o), .btnd_o(btnd_o), .btnl_o(btnl_o), .btnr_o(btnr_o),
    .btnc_o(btnc_o), .sw_o(sw_o)
  );

  input_conditioner #(.STABLE_CYCLES(1), .SW_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .btnu_i(btnu), .btnd_i(btnd), .btnl_i(btnl), .btnr_i(btnr), .btnc_i(btnc),
    .sw_i(sw[3:0]),
    .btnu_o(u1_btnu_o), .btnd_o(u1_btnd_o), .btnl_o(u1_btnl_o),
    .btnr_o(u1_btnr_o), .btnc_o(u1_btnc_o), .sw_o(u1_sw_o)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    {btnu, btnd, btnl, btnr, btnc} = 5'b0;
    sw = 16'h0000;

    // Reset state.
    wait_n(3);
    chk("reset_sw", 32'(sw_o), 32'h0);
    chk("reset_btns", 32'({btnu_o, btnd_o, btnl_o, btnr_o, btnc_o}), 32'h0);
    rst = 1'b0;
    wait_n(3);

    // Single held press: pulse exactly 6 edges later, once.
    btnc = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 106; k++) begin
      tick();
      pulses += int'(btnc_o);
      if (k == 2) chk("w1_btnc_early", 32'(u1_btnc_o), 32'h0);
      if (k == 3) chk("w1_btnc_pulse", 32'(u1_btnc_o), 32'h1);
      if (k == 5) chk("btnc_before", 32'(btnc_o), 32'h0);
      if (k == 6) chk("btnc_pulse", 32'(btnc_o), 32'h1);
      if (k == 7) chk("btnc_after", 32'(btnc_o), 32'h0);
    end
    chk("btnc_pulse_count", 32'(pulses), 32'd1);

    // Release produces no pulse.
    btnc = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      pulses += int'(btnc_o);
    end
    chk("btnc_release", 32'(pulses), 32'd0);

    // Bounce shorter than the window never qualifies.
    pulses = 0;
    for (int r = 0; r < 10; r++) begin
      btnu = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(); pulses += int'(btnu_o); end
      btnu = 1'b0;
      for (int k = 0; k < 2; k++) begin tick(); pulses += int'(btnu_o); end
    end
    for (int k = 0; k < 10; k++) begin tick(); pulses += int'(btnu_o); end
    chk("btnu_bounce", 32'(pulses), 32'd0);

    // Switch bus set and cleared.
    sw = 16'hA5A5;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) chk("sw_set_k1", 32'(sw_o), 32'h0000);
      if (k == 3) chk("w1_sw_set", 32'(u1_sw_o), 32'h5);
      if (k == 5) chk("sw_set_k5", 32'(sw_o), 32'h0000);
      if (k == 6) chk("sw_set_k6", 32'(sw_o), 32'hA5A5);
    end
    sw = 16'h0000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) chk("sw_clr_k5", 32'(sw_o), 32'hA5A5);
      if (k == 6) chk("sw_clr_k6", 32'(sw_o), 32'h0000);
    end

    // Simultaneous presses pulse together.
    btnl = 1'b1;
    btnr = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) chk("lr_before", 32'({btnl_o, btnr_o}), 32'h0);
      if (k == 6) chk("lr_pulse", 32'({btnl_o, btnr_o}), 32'h3);
      if (k == 7) chk("lr_after", 32'({btnl_o, btnr_o}), 32'h0);
    end
    btnl = 1'b0;
    btnr = 1'b0;
    wait_n(10);

    // Staggered presses pulse independently.
    btnu = 1'b1;
    wait_n(2);
    btnd = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) chk("stagger_u", 32'({btnu_o, btnd_o}), 32'h2);
      if (k == 6) chk("stagger_d", 32'({btnu_o, btnd_o}), 32'h1);
    end
    btnu = 1'b0;
    btnd = 1'b0;
    wait_n(10);

    // Load switches so the reset clear is observable.
    sw = 16'h00FF;
    wait_n(8);
    chk("sw_preload", 32'(sw_o), 32'h00FF);

    // Reset mid-count on a held button.
    btnd = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin tick(); pulses += int'(btnd_o); end
    rst = 1'b1;
    tick();
    pulses += int'(btnd_o);
    chk("rst_no_early_pulse", 32'(pulses), 32'd0);
    chk("rst_sw_clear", 32'(sw_o), 32'h0000);
    chk("rst_btns_clear", 32'({btnu_o, btnd_o, btnl_o, btnr_o, btnc_o}), 32'h0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      pulses += int'(btnd_o);
      if (k == 5) chk("post_rst_k5", 32'({btnd_o, sw_o}), 32'h0_0000);
      if (k == 6) chk("post_rst_k6", 32'({btnd_o, sw_o}), 32'h1_00FF);
    end
    chk("post_rst_count", 32'(pulses), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_input_conditioner
`default_nettype wire
